// File: rtl/quiz_pkg.sv
// quiz_pkg: shared state encoding, sizes and helpers for the quiz round controller
package quiz_pkg;
    typedef enum logic [2:0] {IDLE, ASK, WAIT, CHECK, RESULT, DONE} state_t;
    localparam int NUM_ROUNDS = 4;
    localparam int ANS_W = 2;
    localparam logic [3:0] LFSR_TAPS = 4'b1100;
    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0) && ((v & (v - 4'b1)) == 4'b0);
    endfunction
    function automatic logic [ANS_W-1:0] onehot_idx(input logic [3:0] v);
        return {v[3] | v[2], v[3] | v[1]};
    endfunction
endpackage

// File: rtl/quiz_lfsr4.sv
// quiz_lfsr4: free-running 4-bit Fibonacci LFSR (x^4+x^3+1) used to pick the pattern
module quiz_lfsr4
    import quiz_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_seed,
    output logic [3:0] o_q
);
    logic [3:0] r_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_q <= i_seed;
        else r_q <= {r_q[2:0], ^(r_q & LFSR_TAPS)};
    end
    assign o_q = r_q;
endmodule

// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: four-question game sequencer with press capture, timeout and scoring
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int RESULT_CYCLES = 25_000_000,
    parameter int CNT_W = 26,
    parameter logic [3:0] LFSR_SEED = 4'b1001
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_btn,
    input  logic             i_correct_ans,
    output logic [ANS_W-1:0] o_pattern,
    output logic [ANS_W-1:0] o_round,
    output logic [ANS_W-1:0] o_answer,
    output logic             o_ask,
    output logic             o_result_valid,
    output logic             o_result_ok,
    output logic             o_result_timeout,
    output logic [2:0]       o_score,
    output logic             o_game_over
);
    localparam logic [CNT_W-1:0] T_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(RESULT_CYCLES - 1);
    localparam logic [ANS_W-1:0] LAST_ROUND = ANS_W'(NUM_ROUNDS - 1);

    state_t r_state, w_state;
    logic [CNT_W-1:0] r_timer, w_timer;
    logic [ANS_W-1:0] r_pattern, w_pattern, r_round, w_round, r_answer, w_answer;
    logic [2:0] r_score, w_score;
    logic r_armed, w_armed, r_ok, w_ok, r_to, w_to;
    logic [3:0] w_lfsr;
    logic w_press, w_unused;

    quiz_lfsr4 u_lfsr (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_seed (LFSR_SEED),
        .o_q    (w_lfsr)
    );

    assign w_unused = ^w_lfsr[3:2];
    // arming requires a released button first, so a held press cannot answer the next question
    assign w_press = r_armed && is_onehot(i_btn);

    always_comb begin
        w_state = r_state;
        w_timer = r_timer;
        w_pattern = r_pattern;
        w_round = r_round;
        w_answer = r_answer;
        w_score = r_score;
        w_armed = r_armed;
        w_ok = r_ok;
        w_to = r_to;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_pattern = w_lfsr[1:0];
                    w_round = '0;
                    w_score = '0;
                    w_state = ASK;
                end
            end
            ASK: begin
                w_timer = T_LOAD;
                w_armed = 1'b0;
                w_state = WAIT;
            end
            WAIT: begin
                if (i_btn == 4'b0) w_armed = 1'b1;
                if (w_press) begin
                    w_answer = onehot_idx(i_btn);
                    w_state = CHECK;
                end else if (r_timer == '0) begin
                    w_ok = 1'b0;
                    w_to = 1'b1;
                    w_timer = R_LOAD;
                    w_state = RESULT;
                end else begin
                    w_timer = r_timer - 1'b1;
                end
            end
            CHECK: begin
                w_ok = i_correct_ans;
                w_to = 1'b0;
                w_score = r_score + 3'(i_correct_ans);
                w_timer = R_LOAD;
                w_state = RESULT;
            end
            RESULT: begin
                if (r_timer != '0) w_timer = r_timer - 1'b1;
                else if (r_round == LAST_ROUND) w_state = DONE;
                else begin
                    w_round = r_round + 1'b1;
                    w_state = ASK;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_pattern <= '0;
            r_round <= '0;
            r_answer <= '0;
            r_score <= '0;
            r_armed <= 1'b0;
            r_ok <= 1'b0;
            r_to <= 1'b0;
        end else begin
            r_state <= w_state;
            r_timer <= w_timer;
            r_pattern <= w_pattern;
            r_round <= w_round;
            r_answer <= w_answer;
            r_score <= w_score;
            r_armed <= w_armed;
            r_ok <= w_ok;
            r_to <= w_to;
        end
    end

    assign o_pattern = r_pattern;
    assign o_round = r_round;
    assign o_answer = r_answer;
    assign o_ask = (r_state == ASK) || (r_state == WAIT);
    assign o_result_valid = (r_state == RESULT);
    assign o_result_ok = r_ok;
    assign o_result_timeout = r_to;
    assign o_score = r_score;
    assign o_game_over = (r_state == DONE);
endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb_quiz_round_ctrl: randomized game play checked against a question-level reference model
module tb_quiz_round_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, correct_ans;
    logic [3:0] btn = 4'b0;
    logic [1:0] pattern, round, answer;
    logic ask, result_valid, result_ok, result_timeout, game_over;
    logic [2:0] score;
    logic [3:0] m_lfsr;
    logic [1:0] exp_pat;
    int total = 0, bad = 0, exp_score = 0;

    quiz_round_ctrl #(
        .TIMEOUT_CYCLES(8),
        .RESULT_CYCLES (2),
        .CNT_W         (4),
        .LFSR_SEED     (4'b1001)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_btn           (btn),
        .i_correct_ans   (correct_ans),
        .o_pattern       (pattern),
        .o_round         (round),
        .o_answer        (answer),
        .o_ask           (ask),
        .o_result_valid  (result_valid),
        .o_result_ok     (result_ok),
        .o_result_timeout(result_timeout),
        .o_score         (score),
        .o_game_over     (game_over)
    );

    always #5 clk = ~clk;
    assign correct_ans = (answer == round);

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= 4'b1001;
        else m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_start(input int mode);
        return (mode == 2) ? 1'($urandom % 2) : 1'b0;
    endfunction

    // entered with the DUT in ASK for question q
    task automatic question(input int q, input int mode);
        logic [3:0] seq[8];
        logic [3:0] bask;
        logic armed, acc;
        int d, idx, r;
        bask = 4'($urandom);
        d = $urandom_range(1, 3);
        for (int j = 0; j < 8; j++) begin
            r = $urandom % 3;
            case (mode)
                0: seq[j] = (j < d) ? 4'b0 : (j == d) ? 4'(1 << q) : 4'($urandom);
                1: seq[j] = 4'b0;
                2: seq[j] = (r == 0) ? 4'b0 : (r == 1) ? 4'(1 << ($urandom % 4)) : 4'($urandom);
                default: seq[j] = (j < 3) ? 4'b0001 : (j == 3 || j == 6) ? 4'b0 :
                                  (j < 6) ? 4'b0011 : 4'(1 << q);
            endcase
        end
        if (mode == 1) bask = 4'b0;
        if (mode == 3) bask = 4'b0001;
        chk("ask_in_ask", 8'(ask), 8'd1);
        chk("round", 8'(round), 8'(q));
        chk("rv_in_ask", 8'(result_valid), 8'd0);
        btn = bask;
        start = rnd_start(mode);
        tick();
        armed = 1'b0;
        acc = 1'b0;
        idx = 0;
        for (int j = 0; j < 8 && !acc; j++) begin
            chk("ask_in_wait", 8'(ask), 8'd1);
            chk("rv_in_wait", 8'(result_valid), 8'd0);
            btn = seq[j];
            start = rnd_start(mode);
            tick();
            if (armed && $countones(seq[j]) == 1) begin
                acc = 1'b1;
                for (int k = 0; k < 4; k++) if (seq[j][k]) idx = k;
            end else if (seq[j] == 4'b0) armed = 1'b1;
        end
        btn = 4'($urandom);
        start = rnd_start(mode);
        if (acc) begin
            chk("answer", 8'(answer), 8'(idx));
            chk("rv_in_check", 8'(result_valid), 8'd0);
            chk("ask_in_check", 8'(ask), 8'd0);
            tick();
        end
        if (acc && idx == q) exp_score++;
        chk("rv_result", 8'(result_valid), 8'd1);
        chk("result_ok", 8'(result_ok), 8'(acc && idx == q));
        chk("result_timeout", 8'(result_timeout), 8'(!acc));
        chk("score", 8'(score), 8'(exp_score));
        chk("round_result", 8'(round), 8'(q));
        btn = 4'($urandom);
        start = rnd_start(mode);
        tick();
        chk("rv_hold", 8'(result_valid), 8'd1);
        btn = 4'b0;
        start = 1'b0;
        tick();
    endtask

    task automatic begin_game();
        exp_pat = m_lfsr[1:0];
        start = 1'b1;
        btn = 4'($urandom);
        tick();
        start = 1'b0;
        chk("start_pattern", 8'(pattern), 8'(exp_pat));
        chk("start_score", 8'(score), 8'd0);
        chk("start_round", 8'(round), 8'd0);
        chk("start_over", 8'(game_over), 8'd0);
        exp_score = 0;
    endtask

    task automatic play_game(input int mode, input logic chk_seed);
        begin_game();
        if (chk_seed) chk("seed_pattern", 8'(pattern), 8'b01);
        for (int q = 0; q < 4; q++) begin
            chk("pattern_hold", 8'(pattern), 8'(exp_pat));
            question(q, mode);
        end
        chk("game_over", 8'(game_over), 8'd1);
        chk("done_round", 8'(round), 8'd3);
        chk("done_score", 8'(score), 8'(exp_score));
        chk("done_ask", 8'(ask), 8'd0);
        for (int i = 0; i < 3; i++) begin
            btn = 4'($urandom);
            tick();
        end
        btn = 4'b0;
        chk("done_hold_over", 8'(game_over), 8'd1);
        chk("done_hold_score", 8'(score), 8'(exp_score));
        chk("done_hold_pattern", 8'(pattern), 8'(exp_pat));
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ask", 8'(ask), 8'd0);
        chk("rst_outs", {pattern, round, answer, score[1:0]}, 8'd0);
        chk("rst_flags", {1'b0, score[2], result_valid, result_ok, result_timeout, game_over}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            btn = 4'($urandom);
            tick();
            chk("idle_ask", 8'(ask), 8'd0);
        end
        btn = 4'b0;
        play_game(0, 1'b0);
        chk("all_correct", 8'(score), 8'd4);
        play_game(1, 1'b0);
        chk("all_timeout", 8'(score), 8'd0);
        play_game(3, 1'b0);
        begin_game();
        question(0, 0);
        question(1, 0);
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ask", 8'(ask), 8'd0);
        chk("arst_outs", {pattern, round, answer, score[1:0]}, 8'd0);
        chk("arst_flags", {1'b0, score[2], result_valid, result_ok, result_timeout, game_over}, 8'd0);
        @(posedge clk);
        #1;
        chk("arst_hold", 8'(ask), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        play_game(0, 1'b1);
        for (int g = 0; g < 6; g++) play_game(2, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
